// File: rtl/a5_1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : a5_1_pkg
//  Description : Shared constants for the A5/1 keystream sequencer: register
//                lengths, feedback tap masks, clocking-bit positions and the
//                controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package a5_1_pkg;

    localparam int R1_LEN = 19;
    localparam int R2_LEN = 22;
    localparam int R3_LEN = 23;

    // Feedback taps: R1 {13,16,17,18}, R2 {20,21}, R3 {7,20,21,22}
    localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;
    localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;
    localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;

    localparam int R1_CLK = 8;
    localparam int R2_CLK = 10;
    localparam int R3_CLK = 10;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_LOAD_KEY   = 3'd1;
    localparam state_t ST_LOAD_FRAME = 3'd2;
    localparam state_t ST_MIX        = 3'd3;
    localparam state_t ST_GEN        = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/a5_1_keystream_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : a5_1_keystream_ctrl_if
//  Description : Request / keystream handshake bundle between the frame
//                scheduler (master) and the keystream controller (slave).
//                start,key,frame : request side
//                busy,done       : status
//                ks_valid/ks_ready/ks_bit/ks_last : keystream stream
//  Revision    : 1.0 - initial release
// ============================================================================
interface a5_1_keystream_ctrl_if #(
    parameter int KEY_LEN   = 64,
    parameter int FRAME_LEN = 22
);
    logic                 start;
    logic [KEY_LEN-1:0]   key;
    logic [FRAME_LEN-1:0] frame;
    logic                 busy;
    logic                 ks_valid;
    logic                 ks_ready;
    logic                 ks_bit;
    logic                 ks_last;
    logic                 done;

    modport master (
        output start, key, frame, ks_ready,
        input  busy, ks_valid, ks_bit, ks_last, done
    );

    modport slave (
        input  start, key, frame, ks_ready,
        output busy, ks_valid, ks_bit, ks_last, done
    );
endinterface
`default_nettype wire

// File: rtl/a5_1_lfsr_bank.sv
`default_nettype none
// ============================================================================
//  Module      : a5_1_lfsr_bank
//  Description : The three A5/1 shift registers.
//                clr      : zero all registers
//                step_all : step every register, in_bit XORed into bit 0
//                step_maj : majority-clocked step
//                ks_bit   : R1[18]^R2[21]^R3[22] of the current state
//  Revision    : 1.0 - initial release
// ============================================================================
module a5_1_lfsr_bank
    import a5_1_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic step_all,
    input  wire logic step_maj,
    input  wire logic in_bit,
    output logic      ks_bit
);

    logic [R1_LEN-1:0] r_r1;
    logic [R2_LEN-1:0] r_r2;
    logic [R3_LEN-1:0] r_r3;

    logic w_fb1, w_fb2, w_fb3;
    logic w_maj;
    logic w_en1, w_en2, w_en3;
    logic w_inj;

    always_comb begin
        w_fb1 = ^(r_r1 & R1_TAPS);
        w_fb2 = ^(r_r2 & R2_TAPS);
        w_fb3 = ^(r_r3 & R3_TAPS);
        w_maj = (r_r1[R1_CLK] & r_r2[R2_CLK]) |
                (r_r1[R1_CLK] & r_r3[R3_CLK]) |
                (r_r2[R2_CLK] & r_r3[R3_CLK]);
        // A register moves only when its clocking bit agrees with the majority
        w_en1 = step_all | (step_maj & (r_r1[R1_CLK] == w_maj));
        w_en2 = step_all | (step_maj & (r_r2[R2_CLK] == w_maj));
        w_en3 = step_all | (step_maj & (r_r3[R3_CLK] == w_maj));
        w_inj = step_all & in_bit;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_r1 <= '0;
            r_r2 <= '0;
            r_r3 <= '0;
        end else begin
            if (w_en1) r_r1 <= {r_r1[R1_LEN-2:0], w_fb1 ^ w_inj};
            if (w_en2) r_r2 <= {r_r2[R2_LEN-2:0], w_fb2 ^ w_inj};
            if (w_en3) r_r3 <= {r_r3[R3_LEN-2:0], w_fb3 ^ w_inj};
        end
    end

    assign ks_bit = r_r1[R1_LEN-1] ^ r_r2[R2_LEN-1] ^ r_r3[R3_LEN-1];

endmodule
`default_nettype wire

// File: rtl/a5_1_keystream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : a5_1_keystream_ctrl
//  Description : Sequencer for the A5/1 datapath. On start it latches key and
//                frame, clears the registers, loads key then frame bits, runs
//                WARMUP+1 majority steps and streams KS_LEN keystream bits
//                over a valid/ready handshake, pulsing done after the last.
//                clk, rst : clock, synchronous active-high reset
//                bus      : slave side of a5_1_keystream_ctrl_if
//  Revision    : 1.0 - initial release
// ============================================================================
module a5_1_keystream_ctrl
    import a5_1_pkg::*;
#(
    parameter int KEY_LEN   = 64,
    parameter int FRAME_LEN = 22,
    parameter int WARMUP    = 100,
    parameter int KS_LEN    = 228
) (
    input  wire logic              clk,
    input  wire logic              rst,
    a5_1_keystream_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(max3(KEY_LEN, WARMUP + 1, KS_LEN));

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [KEY_LEN-1:0]   r_key_sh;
    logic [FRAME_LEN-1:0] r_frame_sh;
    logic                 r_busy;
    logic                 r_ks_valid;
    logic                 r_done;

    logic w_clr, w_step_all, w_step_maj, w_in_bit, w_last;

    always_comb begin
        w_clr      = (r_state == ST_IDLE) & bus.start;
        w_step_all = (r_state == ST_LOAD_KEY) | (r_state == ST_LOAD_FRAME);
        w_step_maj = (r_state == ST_MIX) | ((r_state == ST_GEN) & bus.ks_ready);
        // Shadows shift right each load step, so bit 0 is always bit cnt
        w_in_bit   = 1'b0;
        if (r_state == ST_LOAD_KEY)   w_in_bit = r_key_sh[0];
        if (r_state == ST_LOAD_FRAME) w_in_bit = r_frame_sh[0];
        w_last     = (r_state == ST_GEN) & (r_cnt == CNT_W'(KS_LEN - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_key_sh   <= '0;
            r_frame_sh <= '0;
            r_busy     <= 1'b0;
            r_ks_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_key_sh   <= bus.key;
                        r_frame_sh <= bus.frame;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_LOAD_KEY;
                    end
                end
                ST_LOAD_KEY: begin
                    r_key_sh <= r_key_sh >> 1;
                    if (r_cnt == CNT_W'(KEY_LEN - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_LOAD_FRAME;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_LOAD_FRAME: begin
                    r_frame_sh <= r_frame_sh >> 1;
                    if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_MIX;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_MIX: begin
                    // WARMUP+1 steps: the first streamed bit is standard output bit 0
                    if (r_cnt == CNT_W'(WARMUP)) begin
                        r_cnt      <= '0;
                        r_ks_valid <= 1'b1;
                        r_state    <= ST_GEN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_GEN: begin
                    if (bus.ks_ready) begin
                        if (w_last) begin
                            r_cnt      <= '0;
                            r_ks_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_cnt      <= '0;
                    r_ks_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    a5_1_lfsr_bank u_bank (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .step_all (w_step_all),
        .step_maj (w_step_maj),
        .in_bit   (w_in_bit),
        .ks_bit   (bus.ks_bit)
    );

    assign bus.busy     = r_busy;
    assign bus.ks_valid = r_ks_valid;
    assign bus.ks_last  = w_last;
    assign bus.done     = r_done;

endmodule
`default_nettype wire
